// File: rtl/life_stepper.sv
// life_stepper: Game-of-Life generation engine feeding the logic side of a double buffer.
// Define GOL_TORUS_EN for a toroidal grid; otherwise every cell beyond the edges is dead.
module life_stepper #(
   parameter int COLS_WORDS   = 20,
   parameter int ROWS         = 480,
   parameter int READ_LAT     = 2,
   parameter int WORD_SIZE    = 32,
   parameter int LOG_MAX_ADDR = $clog2(ROWS * COLS_WORDS)
) (
   input  logic                    clk_in,
   input  logic                    rst_in,
   input  logic                    start_in,
   input  logic                    ready_in,
   output logic [LOG_MAX_ADDR-1:0] logic_addr_r,
   input  logic [WORD_SIZE-1:0]    logic_data_r,
   output logic [LOG_MAX_ADDR-1:0] logic_addr_w,
   output logic [WORD_SIZE-1:0]    logic_data_w,
   output logic                    logic_wr_en,
   output logic                    swap_out,
   output logic                    busy_out,
   output logic                    done_out,
   output logic [15:0]             gen_count_out,
   output logic [2:0]              dbg_state_out
);

   localparam int AW = LOG_MAX_ADDR;
   localparam int KW = $clog2(COLS_WORDS + 1);
   localparam int YW = (ROWS > 1) ? $clog2(ROWS) : 1;
`ifdef GOL_TORUS_EN
   localparam logic TORUS = 1'b1;
`else
   localparam logic TORUS = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_WAIT  = 3'd2,
      S_SHIFT = 3'd3,
      S_WRITE = 3'd4,
      S_SWAP  = 3'd5
   } state_t;

   state_t r_state;
   state_t w_next_state;

   logic [KW-1:0]               r_k;
   logic [YW-1:0]               r_y;
   logic [AW-1:0]               r_row_base;
   logic [1:0]                  r_slot;
   logic                        r_prime;
   logic [2:0][WORD_SIZE-1:0]   r_left;
   logic [2:0][WORD_SIZE-1:0]   r_centre;
   logic [2:0][WORD_SIZE-1:0]   r_right;
   logic [2:0][WORD_SIZE-1:0]   r_fetch;
   logic [READ_LAT:0]           r_pipe_act;
   logic [READ_LAT:0]           r_pipe_real;
   logic [READ_LAT:0][1:0]      r_pipe_slot;

   logic [AW-1:0]               r_addr_r;
   logic [AW-1:0]               r_addr_w;
   logic [WORD_SIZE-1:0]        r_data_w;
   logic                        r_wr_en;
   logic                        r_swap;
   logic                        r_done;
   logic                        r_busy;
   logic [15:0]                 r_gen;

   logic                        w_accept;
   logic                        w_last_col;
   logic                        w_last_row;
   logic                        w_pipe_pend;
   logic                        w_rd_valid;
   logic [KW-1:0]               w_col;
   logic [AW-1:0]               w_rd_row;
   logic [AW-1:0]               w_rd_addr;
   logic [2:0][WORD_SIZE+1:0]   w_ext;
   logic [3:0]                  w_cnt;
   logic [WORD_SIZE-1:0]        w_next_word;

   assign w_accept    = (r_state == S_IDLE) && start_in && ready_in;
   assign w_last_col  = (r_k == KW'(COLS_WORDS));
   assign w_last_row  = (r_y == YW'(ROWS - 1));
   assign w_pipe_pend = |r_pipe_act[READ_LAT-1:0];

   assign logic_addr_r  = r_addr_r;
   assign logic_addr_w  = r_addr_w;
   assign logic_data_w  = r_data_w;
   assign logic_wr_en   = r_wr_en;
   assign swap_out      = r_swap;
   assign done_out      = r_done;
   assign busy_out      = r_busy;
   assign gen_count_out = r_gen;
   assign dbg_state_out = r_state;

   // Column to fetch for the current ISSUE burst.
   always_comb begin
      w_col = r_k;
`ifdef GOL_TORUS_EN
      if (r_prime) begin
         w_col = KW'(COLS_WORDS - 1);
      end else if (w_last_col) begin
         w_col = '0;
      end
`endif
   end

   // Row base for slot 0/1/2 = rows y-1, y, y+1; off-grid slots are marked invalid.
   always_comb begin
      w_rd_valid = 1'b1;
      w_rd_row   = r_row_base;
      case (r_slot)
         2'd0: begin
            if (r_y == '0) begin
`ifdef GOL_TORUS_EN
               w_rd_row = AW'((ROWS - 1) * COLS_WORDS);
`else
               w_rd_valid = 1'b0;
`endif
            end else begin
               w_rd_row = r_row_base - AW'(COLS_WORDS);
            end
         end
         2'd2: begin
            if (w_last_row) begin
`ifdef GOL_TORUS_EN
               w_rd_row = '0;
`else
               w_rd_valid = 1'b0;
`endif
            end else begin
               w_rd_row = r_row_base + AW'(COLS_WORDS);
            end
         end
         default: w_rd_row = r_row_base;
      endcase
`ifndef GOL_TORUS_EN
      if (w_last_col) begin
         w_rd_valid = 1'b0;
      end
`endif
      w_rd_addr = w_rd_row + AW'(w_col);
   end

   // Each window row is widened by one neighbour bit on each side from the adjacent columns.
   always_comb begin
      w_ext       = '0;
      w_cnt       = '0;
      w_next_word = '0;
      for (int r = 0; r < 3; r++) begin
         w_ext[r] = {r_right[r][0], r_centre[r], r_left[r][WORD_SIZE-1]};
      end
      for (int b = 0; b < WORD_SIZE; b++) begin
         w_cnt = 4'(w_ext[0][b]) + 4'(w_ext[0][b+1]) + 4'(w_ext[0][b+2])
               + 4'(w_ext[1][b]) + 4'(w_ext[1][b+2])
               + 4'(w_ext[2][b]) + 4'(w_ext[2][b+1]) + 4'(w_ext[2][b+2]);
         w_next_word[b] = (w_cnt == 4'd3) || (r_centre[1][b] && (w_cnt == 4'd2));
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_next_state = S_ISSUE;
         S_ISSUE: if (r_slot == 2'd2) w_next_state = S_WAIT;
         S_WAIT:  if (!w_pipe_pend) w_next_state = S_SHIFT;
         S_SHIFT: w_next_state = (!r_prime && (r_k != '0)) ? S_WRITE : S_ISSUE;
         S_WRITE: w_next_state = (w_last_col && w_last_row) ? S_SWAP : S_ISSUE;
         S_SWAP:  w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_k         <= '0;
         r_y         <= '0;
         r_row_base  <= '0;
         r_slot      <= '0;
         r_prime     <= 1'b0;
         r_left      <= '0;
         r_centre    <= '0;
         r_right     <= '0;
         r_fetch     <= '0;
         r_pipe_act  <= '0;
         r_pipe_real <= '0;
         r_pipe_slot <= '0;
         r_addr_r    <= '0;
         r_addr_w    <= '0;
         r_data_w    <= '0;
         r_wr_en     <= 1'b0;
         r_swap      <= 1'b0;
         r_done      <= 1'b0;
         r_busy      <= 1'b0;
         r_gen       <= '0;
      end else begin
         r_wr_en <= 1'b0;
         r_swap  <= 1'b0;
         r_done  <= 1'b0;
         // Tags follow each issued read so its word lands in the right slot READ_LAT cycles later.
         r_pipe_act  <= {r_pipe_act[READ_LAT-1:0], (r_state == S_ISSUE)};
         r_pipe_real <= {r_pipe_real[READ_LAT-1:0], w_rd_valid};
         r_pipe_slot <= {r_pipe_slot[READ_LAT-1:0], r_slot};
         if (r_pipe_act[READ_LAT]) begin
            r_fetch[r_pipe_slot[READ_LAT]] <= r_pipe_real[READ_LAT] ? logic_data_r : '0;
         end
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_busy     <= 1'b1;
                  r_y        <= '0;
                  r_row_base <= '0;
                  r_k        <= '0;
                  r_slot     <= '0;
                  r_prime    <= TORUS;
                  r_left     <= '0;
                  r_centre   <= '0;
                  r_right    <= '0;
               end
            end
            S_ISSUE: begin
               if (w_rd_valid) begin
                  r_addr_r <= w_rd_addr;
               end
               r_slot <= (r_slot == 2'd2) ? 2'd0 : r_slot + 2'd1;
            end
            S_SHIFT: begin
               r_left   <= r_centre;
               r_centre <= r_right;
               r_right  <= r_fetch;
               if (r_prime) begin
                  r_prime <= 1'b0;
               end else if (r_k == '0) begin
                  r_k <= KW'(1);
               end
            end
            S_WRITE: begin
               r_wr_en  <= 1'b1;
               r_addr_w <= r_row_base + AW'(r_k) - AW'(1);
               r_data_w <= w_next_word;
               if (!w_last_col) begin
                  r_k <= r_k + KW'(1);
               end else if (!w_last_row) begin
                  r_y        <= r_y + YW'(1);
                  r_row_base <= r_row_base + AW'(COLS_WORDS);
                  r_k        <= '0;
                  r_prime    <= TORUS;
                  r_left     <= '0;
                  r_centre   <= '0;
                  r_right    <= '0;
               end
            end
            S_SWAP: begin
               r_swap <= 1'b1;
               r_done <= 1'b1;
               r_busy <= 1'b0;
               r_gen  <= r_gen + 16'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_life_stepper.sv
// Directed bench for life_stepper on a 16x8 grid with a behavioural double buffer.
module tb_life_stepper;

   localparam int C  = 2;
   localparam int R  = 8;
   localparam int WS = 8;
   localparam int RL = 2;
   localparam int AW = 4;
   localparam int NW = C * R;

   logic          clk_in = 1'b0;
   logic          rst_in;
   logic          start_in;
   logic          ready_in;
   logic [AW-1:0] logic_addr_r;
   logic [WS-1:0] logic_data_r;
   logic [AW-1:0] logic_addr_w;
   logic [WS-1:0] logic_data_w;
   logic          logic_wr_en;
   logic          swap_out;
   logic          busy_out;
   logic          done_out;
   logic [15:0]   gen_count_out;
   logic [2:0]    dbg_state_out;

   int total = 0;
   int bad   = 0;
   int wr_cnt, exp_addr, order_err, nz_wr, swap_cnt, coinc_err, nonidle;

   logic [WS-1:0] mem [0:1][0:NW-1];
   logic          cur = 1'b0;
   logic [WS-1:0] q1;
   logic [WS-1:0] img [0:NW-1];
   logic [WS-1:0] exp_grid [0:NW-1];

   // clock / reset
   always #5 clk_in = ~clk_in;

   life_stepper #(
      .COLS_WORDS(C), .ROWS(R), .READ_LAT(RL), .WORD_SIZE(WS), .LOG_MAX_ADDR(AW)
   ) dut (
      .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .ready_in(ready_in),
      .logic_addr_r(logic_addr_r), .logic_data_r(logic_data_r),
      .logic_addr_w(logic_addr_w), .logic_data_w(logic_data_w), .logic_wr_en(logic_wr_en),
      .swap_out(swap_out), .busy_out(busy_out), .done_out(done_out),
      .gen_count_out(gen_count_out), .dbg_state_out(dbg_state_out)
   );

   // double buffer model: two-stage read, writes into the back buffer, flip on swap
   always @(posedge clk_in) begin
      q1           <= mem[cur][logic_addr_r];
      logic_data_r <= q1;
      if (logic_wr_en) mem[!cur][logic_addr_w] <= logic_data_w;
      if (swap_out) cur <= !cur;
   end

   // write/swap monitor
   always @(posedge clk_in) begin
      if (logic_wr_en) begin
         if (int'(logic_addr_w) != exp_addr) order_err++;
         if (logic_data_w != '0) nz_wr++;
         exp_addr++;
         wr_cnt++;
      end
      if (swap_out) swap_cnt++;
      if (swap_out !== done_out) coinc_err++;
      if (dbg_state_out != 3'd0) nonidle++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clr_stats();
      wr_cnt = 0; exp_addr = 0; order_err = 0; nz_wr = 0;
      swap_cnt = 0; coinc_err = 0; nonidle = 0;
   endtask

   task automatic img_clear();
      for (int w = 0; w < NW; w++) img[w] = '0;
   endtask

   task automatic img_set(input int x, input int y);
      img[y * C + x / WS][x % WS] = 1'b1;
   endtask

   task automatic img_load();
      @(negedge clk_in);
      for (int w = 0; w < NW; w++) mem[cur][w] <= img[w];
   endtask

   task automatic exp_from_img();
      for (int w = 0; w < NW; w++) exp_grid[w] = img[w];
   endtask

   task automatic check_grid(input string tag);
      for (int w = 0; w < NW; w++)
         check($sformatf("%s_w%0d", tag, w), 32'(mem[cur][w]), 32'(exp_grid[w]));
   endtask

   task automatic pulse_start();
      @(negedge clk_in);
      start_in = 1'b1;
      @(negedge clk_in);
      start_in = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (done_out !== 1'b1 && n < 3000) begin
         @(posedge clk_in);
         #1;
         n++;
      end
      check({tag, "_timeout"}, 32'(n < 3000), 32'd1);
      check({tag, "_swap_with_done"}, 32'(swap_out), 32'd1);
      @(posedge clk_in);
      #1;
   endtask

   task automatic run_gen(input string tag);
      pulse_start();
      wait_done(tag);
   endtask

   initial begin
      int n;
      rst_in = 1'b1; start_in = 1'b0; ready_in = 1'b1;
      repeat (3) @(negedge clk_in);
      check("rst_wr_en", 32'(logic_wr_en), 0);
      check("rst_busy", 32'(busy_out), 0);
      check("rst_swap", 32'(swap_out), 0);
      check("rst_done", 32'(done_out), 0);
      check("rst_gen", 32'(gen_count_out), 0);
      check("rst_addr_r", 32'(logic_addr_r), 0);
      check("rst_state", 32'(dbg_state_out), 0);
      @(negedge clk_in);
      rst_in = 1'b0;

      // start with ready low is dropped
      clr_stats();
      ready_in = 1'b0;
      pulse_start();
      repeat (20) @(negedge clk_in);
      check("hs_busy", 32'(busy_out), 0);
      check("hs_nonidle", 32'(nonidle), 0);
      check("hs_addr_r", 32'(logic_addr_r), 0);
      check("hs_writes", 32'(wr_cnt), 0);
      ready_in = 1'b1;

      // blinker, with an extra start mid-generation
      img_clear(); img_set(10, 5); img_set(11, 5); img_set(12, 5); img_load();
      img_clear(); img_set(11, 4); img_set(11, 5); img_set(11, 6); exp_from_img();
      clr_stats();
      pulse_start();
      check("bl_busy_rise", 32'(busy_out), 1);
      repeat (40) @(negedge clk_in);
      pulse_start();
      wait_done("bl");
      repeat (30) @(negedge clk_in);
      check_grid("bl");
      check("bl_writes", 32'(wr_cnt), NW);
      check("bl_order", 32'(order_err), 0);
      check("bl_swaps", 32'(swap_cnt), 1);
      check("bl_coinc", 32'(coinc_err), 0);
      check("bl_gen", 32'(gen_count_out), 1);
      check("bl_busy_low", 32'(busy_out), 0);

      // reset during row 4, then recompute vertical -> horizontal blinker
      img_clear(); img_set(10, 5); img_set(11, 5); img_set(12, 5); exp_from_img();
      clr_stats();
      pulse_start();
      n = 0;
      while (wr_cnt < 9 && n < 1000) begin
         @(negedge clk_in);
         n++;
      end
      check("rm_reach_row4", 32'(n < 1000), 1);
      #3;
      rst_in = 1'b1;
      #1;
      check("rm_wr_en", 32'(logic_wr_en), 0);
      check("rm_busy", 32'(busy_out), 0);
      check("rm_swap", 32'(swap_out), 0);
      check("rm_done", 32'(done_out), 0);
      check("rm_gen", 32'(gen_count_out), 0);
      check("rm_addr_w", 32'(logic_addr_w), 0);
      check("rm_state", 32'(dbg_state_out), 0);
      @(negedge clk_in);
      rst_in = 1'b0;
      clr_stats();
      run_gen("rm");
      check_grid("rm");
      check("rm_gen_after", 32'(gen_count_out), 1);
      check("rm_writes", 32'(wr_cnt), NW);
      check("rm_order", 32'(order_err), 0);

      // block straddling a word boundary stays put for three generations
      @(negedge clk_in); rst_in = 1'b1;
      @(negedge clk_in); rst_in = 1'b0;
      img_clear();
      img_set(WS - 1, 2); img_set(WS, 2); img_set(WS - 1, 3); img_set(WS, 3);
      img_load(); exp_from_img();
      clr_stats();
      run_gen("blk1"); run_gen("blk2"); run_gen("blk3");
      check_grid("blk");
      check("blk_gen", 32'(gen_count_out), 3);
      check("blk_swaps", 32'(swap_cnt), 3);
      check("blk_writes", 32'(wr_cnt), 3 * NW);

      // horizontal triple on the top edge
      img_clear(); img_set(10, 0); img_set(11, 0); img_set(12, 0); img_load();
      img_clear(); img_set(11, 0); img_set(11, 1);
`ifdef GOL_TORUS_EN
      img_set(11, R - 1);
`endif
      exp_from_img();
      run_gen("top");
      check_grid("top");
      check("top_gen", 32'(gen_count_out), 4);

      // empty grid
      img_clear(); img_load(); exp_from_img();
      clr_stats();
      run_gen("emp");
      check_grid("emp");
      check("emp_nonzero", 32'(nz_wr), 0);
      check("emp_order", 32'(order_err), 0);
      check("emp_last_addr", 32'(exp_addr), NW);
      check("emp_writes", 32'(wr_cnt), NW);
      check("emp_coinc", 32'(coinc_err), 0);
      check("emp_swaps", 32'(swap_cnt), 1);
      check("emp_gen", 32'(gen_count_out), 5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
